// File: rtl/countdown_datapath.sv
// BCD minutes:seconds countdown with programmable setting registers and
// auto-repeat increment. Optional chime window enabled by ALARM_CHIME_EN.
module countdown_datapath #(
  parameter logic [7:0] MAX_MINUTES = 8'h99
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sec_tick,
  input  logic       prog_mode,
  input  logic       increment_seconds,
  input  logic       increment_minutes,
  input  logic       load_timer,
  input  logic       main_timer_enable,
  output logic [7:0] disp_min,
  output logic [7:0] disp_sec,
  output logic       timer_done,
  output logic       chime
);

  logic [7:0] set_min, set_sec;
  logic [7:0] cnt_min, cnt_sec;
  logic       inc_sec_q, inc_min_q;
  logic       inc_sec_fire, inc_min_fire;
  logic [7:0] set_sec_next, set_min_next;
  logic [7:0] dec_min, dec_sec;
  logic       cnt_zero, dec_zero;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Fire on the rising edge, then once per sec_tick while held
  assign inc_sec_fire = prog_mode & increment_seconds & (~inc_sec_q | sec_tick);
  assign inc_min_fire = prog_mode & increment_minutes & (~inc_min_q | sec_tick);

  assign set_sec_next = (set_sec >= 8'h59)       ? 8'h00 : bcd_inc(set_sec);
  assign set_min_next = (set_min >= MAX_MINUTES) ? 8'h00 : bcd_inc(set_min);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inc_sec_q <= 1'b0;
      inc_min_q <= 1'b0;
      set_sec   <= 8'h00;
      set_min   <= 8'h00;
    end else begin
      inc_sec_q <= prog_mode & increment_seconds;
      inc_min_q <= prog_mode & increment_minutes;
      if (inc_sec_fire) set_sec <= set_sec_next;
      if (inc_min_fire) set_min <= set_min_next;
    end
  end

  // Seconds 00 borrows a minute; caller guarantees count is non-zero
  assign cnt_zero = (cnt_min == 8'h00) && (cnt_sec == 8'h00);
  assign dec_sec  = (cnt_sec == 8'h00) ? 8'h59 : bcd_dec(cnt_sec);
  assign dec_min  = (cnt_sec == 8'h00) ? bcd_dec(cnt_min) : cnt_min;
  assign dec_zero = (dec_min == 8'h00) && (dec_sec == 8'h00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_min    <= 8'h00;
      cnt_sec    <= 8'h00;
      timer_done <= 1'b0;
    end else if (load_timer) begin
      cnt_min    <= set_min;
      cnt_sec    <= set_sec;
      timer_done <= 1'b0;
    end else if (main_timer_enable) begin
      if (cnt_zero) begin
        timer_done <= 1'b1;
      end else if (sec_tick) begin
        cnt_min <= dec_min;
        cnt_sec <= dec_sec;
        if (dec_zero) timer_done <= 1'b1;
      end
    end
  end

  assign disp_min = prog_mode ? set_min : cnt_min;
  assign disp_sec = prog_mode ? set_sec : cnt_sec;

`ifdef ALARM_CHIME_EN
  logic       done_q;
  logic [3:0] chime_left;

  // Ten toggles in the window leave chime low when it closes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q     <= 1'b0;
      chime_left <= 4'd0;
      chime      <= 1'b0;
    end else begin
      done_q <= timer_done;
      if (load_timer) begin
        chime_left <= 4'd0;
        chime      <= 1'b0;
      end else if (timer_done && !done_q) begin
        chime_left <= 4'd10;
        chime      <= 1'b0;
      end else if (sec_tick && chime_left != 4'd0) begin
        chime_left <= chime_left - 4'd1;
        chime      <= ~chime;
      end
    end
  end
`else
  assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_datapath.sv
// Directed bench for countdown_datapath: setting, countdown, load priority,
// async reset and chime window.
module tb_countdown_datapath;

  logic       clk;
  logic       reset_n;
  logic       sec_tick;
  logic       prog_mode;
  logic       increment_seconds;
  logic       increment_minutes;
  logic       load_timer;
  logic       main_timer_enable;
  logic [7:0] disp_min;
  logic [7:0] disp_sec;
  logic       timer_done;
  logic       chime;

  int checks;
  int failures;
  int toggles;
  logic chime_prev;

  countdown_datapath dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .sec_tick          (sec_tick),
    .prog_mode         (prog_mode),
    .increment_seconds (increment_seconds),
    .increment_minutes (increment_minutes),
    .load_timer        (load_timer),
    .main_timer_enable (main_timer_enable),
    .disp_min          (disp_min),
    .disp_sec          (disp_sec),
    .timer_done        (timer_done),
    .chime             (chime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sec(input int n);
    for (int i = 0; i < n; i++) begin
      increment_seconds = 1'b1; step();
      increment_seconds = 1'b0; step();
    end
  endtask

  task automatic pulse_min(input int n);
    for (int i = 0; i < n; i++) begin
      increment_minutes = 1'b1; step();
      increment_minutes = 1'b0; step();
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      sec_tick = 1'b1; step();
      sec_tick = 1'b0; step();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    sec_tick = 1'b0;
    prog_mode = 1'b0;
    increment_seconds = 1'b0;
    increment_minutes = 1'b0;
    load_timer = 1'b0;
    main_timer_enable = 1'b0;
    #12;
    check("rst_disp_min", disp_min, 8'h00);
    check("rst_disp_sec", disp_sec, 8'h00);
    check("rst_done", timer_done, 1'b0);
    check("rst_chime", chime, 1'b0);
    step();
    reset_n = 1'b1;
    step();

    // Seconds setting wraps 59 -> 00 without touching minutes
    prog_mode = 1'b1;
    pulse_sec(59);
    check("set_sec_59", disp_sec, 8'h59);
    pulse_sec(1);
    check("set_sec_wrap", disp_sec, 8'h00);
    check("set_min_no_carry", disp_min, 8'h00);

    // Minutes auto-repeat: edge plus three ticks
    increment_minutes = 1'b1; step();
    check("min_edge", disp_min, 8'h01);
    tick(3);
    check("min_repeat", disp_min, 8'h04);
    increment_minutes = 1'b0; step();
    prog_mode = 1'b0;
    increment_minutes = 1'b1;
    tick(3);
    increment_minutes = 1'b0; step();
    prog_mode = 1'b1; #1;
    check("min_ignored_prog0", disp_min, 8'h04);

    pulse_min(95);
    check("min_99", disp_min, 8'h99);
    pulse_min(1);
    check("min_wrap", disp_min, 8'h00);

    // 01:00 countdown to expiry
    pulse_min(1);
    prog_mode = 1'b0;
    load_timer = 1'b1; step();
    load_timer = 1'b0;
    check("load_min", disp_min, 8'h01);
    check("load_sec", disp_sec, 8'h00);
    check("load_done", timer_done, 1'b0);
    main_timer_enable = 1'b1;
    tick(1);
    check("borrow_min", disp_min, 8'h00);
    check("borrow_sec", disp_sec, 8'h59);
    tick(58);
    check("at_0001_sec", disp_sec, 8'h01);
    check("at_0001_done", timer_done, 1'b0);
    sec_tick = 1'b1; step();
    sec_tick = 1'b0;
    check("expire_sec", disp_sec, 8'h00);
    check("expire_done", timer_done, 1'b1);

    toggles = 0;
    chime_prev = chime;
    for (int i = 0; i < 24; i++) begin
      sec_tick = (i % 2 == 0);
      step();
      if (chime !== chime_prev) toggles++;
      chime_prev = chime;
    end
    sec_tick = 1'b0;
`ifdef ALARM_CHIME_EN
    check("chime_toggles", toggles, 10);
`else
    check("chime_toggles", toggles, 0);
`endif
    check("chime_end", chime, 1'b0);
    check("hold_zero_min", disp_min, 8'h00);
    check("hold_zero_sec", disp_sec, 8'h00);
    main_timer_enable = 1'b0;
    step(); step();
    check("done_sticky", timer_done, 1'b1);

    // Load beats same-cycle decrement
    prog_mode = 1'b1;
    pulse_min(4);
    load_timer = 1'b1; step();
    load_timer = 1'b0;
    pulse_min(97);
    pulse_sec(30);
    check("set_0230_min", disp_min, 8'h02);
    check("set_0230_sec", disp_sec, 8'h30);
    prog_mode = 1'b0; #1;
    check("cnt_0500_min", disp_min, 8'h05);
    check("cnt_0500_done", timer_done, 1'b0);
    main_timer_enable = 1'b1;
    load_timer = 1'b1;
    sec_tick = 1'b1;
    step();
    load_timer = 1'b0;
    sec_tick = 1'b0;
    check("ldpri_min", disp_min, 8'h02);
    check("ldpri_sec", disp_sec, 8'h30);
    check("ldpri_done", timer_done, 1'b0);

    // Async reset mid-count at 03:17
    main_timer_enable = 1'b0;
    prog_mode = 1'b1;
    pulse_min(1);
    pulse_sec(47);
    load_timer = 1'b1; step();
    load_timer = 1'b0;
    prog_mode = 1'b0; #1;
    check("cnt_0317_min", disp_min, 8'h03);
    check("cnt_0317_sec", disp_sec, 8'h17);
    #1 reset_n = 1'b0;
    #1;
    check("arst_min", disp_min, 8'h00);
    check("arst_sec", disp_sec, 8'h00);
    check("arst_done", timer_done, 1'b0);
    check("arst_chime", chime, 1'b0);
    prog_mode = 1'b1; #1;
    check("arst_set_sec", disp_sec, 8'h00);
    prog_mode = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_min", disp_min, 8'h00);
    check("post_rst_sec", disp_sec, 8'h00);
    main_timer_enable = 1'b1;
    step();
    check("done_on_zero", timer_done, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_datapath.md
COUNTDOWN_DATAPATH -- requirements
Module: countdown_datapath

Interface
REQ-001 SHALL have parameter MAX_MINUTES, default 8'h99, upper BCD limit of the minutes setting.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port sec_tick  input  1  one-clk-wide pulse, once per second.
REQ-005 SHALL have port prog_mode  input  1  setting counters may change.
REQ-006 SHALL have port increment_seconds  input  1  level, seconds-up request.
REQ-007 SHALL have port increment_minutes  input  1  level, minutes-up request.
REQ-008 SHALL have port load_timer  input  1  one-clk pulse, copy setting into main count.
REQ-009 SHALL have port main_timer_enable  input  1  allow main count to decrement.
REQ-010 SHALL have port disp_min  output  8  two BCD digits, minutes shown.
REQ-011 SHALL have port disp_sec  output  8  two BCD digits, seconds shown.
REQ-012 SHALL have port timer_done  output  1  registered, main count expired.
REQ-013 SHALL have port chime  output  1  audible alarm drive.

Function
REQ-014 SHALL hold setting registers set_min (BCD 00..MAX_MINUTES) and set_sec (BCD 00..59).
REQ-015 SHALL increment set_sec once on the rising edge of increment_seconds, then once per sec_tick while it stays high (auto-repeat); same for increment_minutes/set_min.
REQ-016 SHALL wrap set_sec 59->00 with no carry into set_min; set_min MAX_MINUTES->00.
REQ-017 SHALL ignore both increment inputs and not arm edge detection while prog_mode=0.
REQ-018 SHALL, when both increment inputs qualify in the same cycle, apply both.
REQ-019 SHALL, on the edge sampling load_timer=1, set cnt_min/cnt_sec to set_min/set_sec and clear timer_done; load beats any same-cycle decrement.
REQ-020 SHALL decrement the main count by one second on each edge with main_timer_enable=1, sec_tick=1, count!=00:00, load_timer=0.
REQ-021 SHALL use BCD borrow: ones 0->9 borrow tens; seconds 00->59 borrow one minute.
REQ-022 SHALL never decrement below 00:00; count holds at zero.
REQ-023 SHALL set timer_done on the same edge a decrement lands on 00:00, or on any edge with main_timer_enable=1 and count already 00:00.
REQ-024 SHALL keep timer_done set until load_timer or reset; main_timer_enable falling does not clear it.
REQ-025 SHALL drive disp_min/disp_sec combinationally from set_* when prog_mode=1, else from cnt_*.

Reset
REQ-026 SHALL, with reset_n low, immediately force set_*, cnt_* to 00, timer_done=0, chime=0, edge-detect and chime state to 0, independent of clk.
REQ-027 SHALL, on reset mid-count, discard the count; first edge after release behaves as from power-up.

Configuration
REQ-028 SHALL, with ALARM_CHIME_EN defined, start a 10-tick chime window on timer_done rising; chime toggles each sec_tick in the window, ends 0; load_timer or reset aborts the window, chime=0.
REQ-029 SHALL, without ALARM_CHIME_EN, tie chime to constant 0 and omit chime logic; port remains.

Verification
REQ-030 SHALL cover: prog_mode=1, one 1-clk increment_seconds pulse from 00:59 -> set 00:00, set_min unchanged.
REQ-031 SHALL cover: prog_mode=1, increment_minutes held across 3 sec_ticks from 00 -> set_min 04; held with prog_mode=0 -> no change.
REQ-032 SHALL cover: set 01:00, load_timer, enable, one sec_tick -> 00:59; 59 more ticks -> 00:00 with timer_done high the same edge.
REQ-033 SHALL cover: load_timer and sec_tick same cycle with count 05:00, set 02:30 -> count 02:30, not 02:29, timer_done 0.
REQ-034 SHALL cover: reset_n pulsed low mid-count at 03:17 -> all outputs 0 asynchronously, count 00:00 after release.
REQ-035 SHALL cover, with ALARM_CHIME_EN: expiry then 10 sec_ticks -> chime toggles 10 times, then stays 0; without macro chime always 0.
